// File: rtl/max31855_spi_responder.sv
// MAX31855-style SPI read-frame responder; pin inputs are oversampled in the clk domain.
// Define MAX31855_CONV_TIMER_EN to refresh the snapshot once per emulated conversion instead of every cycle.
module max31855_spi_responder #(
    parameter int CONV_CYCLES = 800,
    parameter int CBITS       = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        sck,
    input  logic [13:0] tc_temp_in,
    input  logic [11:0] junction_temp_in,
    input  logic [2:0]  fault_in,
    output logic        miso,
    output logic        miso_oe,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;

    if ((2 ** CBITS) <= CONV_CYCLES) begin : g_bad_cbits
        $error("CBITS too narrow for CONV_CYCLES");
    end

    logic        cs_meta_q, cs_sync_q, cs_prev_q;
    logic        sck_meta_q, sck_sync_q, sck_prev_q;
    logic        cs_fall, cs_rise, sck_rise, sck_fall;
    logic [31:0] packed_d;
    logic [31:0] snap_q;
    logic [31:0] shift_q;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        miso_q, miso_oe_q, frame_done_q, busy_q;
    state_t      state_q;

    // cs_n synchronizer resets high so leaving reset never looks like a select
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_meta_q  <= 1'b1;
            cs_sync_q  <= 1'b1;
            cs_prev_q  <= 1'b1;
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
        end else begin
            cs_meta_q  <= cs_n;
            cs_sync_q  <= cs_meta_q;
            cs_prev_q  <= cs_sync_q;
            sck_meta_q <= sck;
            sck_sync_q <= sck_meta_q;
            sck_prev_q <= sck_sync_q;
        end
    end

    assign cs_fall  = cs_prev_q & ~cs_sync_q;
    assign cs_rise  = ~cs_prev_q & cs_sync_q;
    assign sck_rise = ~sck_prev_q & sck_sync_q;
    assign sck_fall = sck_prev_q & ~sck_sync_q;

    assign packed_d = {tc_temp_in, 1'b0, |fault_in, junction_temp_in, 1'b0, fault_in};

`ifdef MAX31855_CONV_TIMER_EN
    localparam logic [CBITS-1:0] CONV_LAST = CBITS'(CONV_CYCLES - 1);
    logic [CBITS-1:0] conv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            conv_q <= '0;
            snap_q <= '0;
        end else if (cs_fall) begin
            conv_q <= '0;
        end else if (cs_sync_q) begin
            if (conv_q == CONV_LAST) begin
                conv_q <= '0;
                snap_q <= packed_d;
            end else begin
                conv_q <= conv_q + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q <= '0;
        end else if (cs_sync_q) begin
            snap_q <= packed_d;
        end
    end
`endif

    // A rising sck still counts even when cs_n rises in the same cycle
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (sck_rise && (bit_cnt_q < 6'd32)) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    if (cs_fall) begin
                        shift_q   <= snap_q;
                        miso_q    <= snap_q[31];
                        bit_cnt_q <= '0;
                        miso_oe_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bit_cnt_q <= bit_cnt_d;
                    if (cs_rise) begin
                        miso_q       <= 1'b0;
                        miso_oe_q    <= 1'b0;
                        busy_q       <= 1'b0;
                        frame_done_q <= (bit_cnt_d == 6'd32);
                        state_q      <= IDLE;
                    end else if (sck_fall) begin
                        shift_q <= {shift_q[30:0], 1'b0};
                        miso_q  <= shift_q[30];
                    end
                end
                default: begin
                    miso_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = miso_oe_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule
